// File: rtl/kangaroo_sram_pkg.sv
// Shared types for the kangaroo work-RAM sequencer (two 1024x4 2114 chips).
// The optional video port is enabled by defining KANGAROO_SRAM_VIDEO_PORT_EN.
package kangaroo_sram_pkg;

  localparam int SRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } sram_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_VID
  } owner_t;

endpackage

// File: rtl/kangaroo_sram_arb.sv
// CPU/video grant logic with a registered last-grant flag for alternation.
// With KANGAROO_SRAM_VIDEO_PORT_EN undefined the arbiter always grants the CPU.
module kangaroo_sram_arb
  import kangaroo_sram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_en,
  input  logic   cpu_req,
  input  logic   vid_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
  owner_t last_grant;

  // Video wins by default; the CPU wins a tie right after a video grant.
  always_comb begin
    grant_valid = cpu_req | vid_req;
    grant_owner = OWN_CPU;
    if (vid_req && !(last_grant == OWN_VID && cpu_req)) begin
      grant_owner = OWN_VID;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWN_CPU;
    end else if (grant_en && grant_valid) begin
      last_grant <= grant_owner;
    end
  end
`else
  logic unused_arb;

  assign grant_valid = cpu_req;
  assign grant_owner = OWN_CPU;
  assign unused_arb  = ^{clk, reset, grant_en, vid_req};
`endif

endmodule

// File: rtl/kangaroo_sram_ctrl.sv
// Access sequencer for a 1K x 8 bank of two 2114 SRAMs (IDLE/SETUP/STROBE/HOLD).
// Define KANGAROO_SRAM_VIDEO_PORT_EN to enable the video read port.
module kangaroo_sram_ctrl
  import kangaroo_sram_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_W        = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [SRAM_DATA_W-1:0] cpu_wdata,
  output logic [SRAM_DATA_W-1:0] cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_wait,
  input  logic                   vid_req,
  input  logic [ADDR_W-1:0]      vid_addr,
  output logic [SRAM_DATA_W-1:0] vid_rdata,
  output logic                   vid_valid,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_cs_n,
  output logic                   ram_we_n,
  output logic [SRAM_DATA_W-1:0] ram_dq_out,
  output logic                   ram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] ram_dq_in
);

  localparam logic [2:0] STROBE_RELOAD = 3'(STROBE_CYCLES - 1);

  sram_state_t state;
  logic [2:0]  strobe_cnt;
  owner_t      owner;
  logic        is_write;
  logic        grant_en;
  logic        grant_valid;
  owner_t      grant_owner;

  assign grant_en = (state == IDLE);
  assign cpu_wait = cpu_req & ~cpu_ack;

  kangaroo_sram_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .grant_en    (grant_en),
    .cpu_req     (cpu_req),
    .vid_req     (vid_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // All pin outputs are registered, so the strobe pattern changes only on clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      strobe_cnt <= '0;
      owner      <= OWN_CPU;
      is_write   <= 1'b0;
      ram_addr   <= '0;
      ram_cs_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_dq_out <= '0;
      ram_dq_oe  <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
      vid_valid  <= 1'b0;
      vid_rdata  <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
      vid_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            is_write   <= (grant_owner == OWN_CPU) && cpu_we;
            ram_addr   <= (grant_owner == OWN_VID) ? vid_addr : cpu_addr;
            ram_dq_out <= ((grant_owner == OWN_CPU) && cpu_we) ? cpu_wdata : '0;
            ram_dq_oe  <= (grant_owner == OWN_CPU) && cpu_we;
            state      <= SETUP;
          end
        end
        SETUP: begin
          strobe_cnt <= STROBE_RELOAD;
          ram_cs_n   <= 1'b0;
          ram_we_n   <= ~is_write;
          state      <= STROBE;
        end
        STROBE: begin
          if (strobe_cnt == 3'd0) begin
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            if (!is_write) begin
              if (owner == OWN_CPU) begin
                cpu_rdata <= ram_dq_in;
              end
`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
              else begin
                vid_rdata <= ram_dq_in;
              end
`endif
            end
            state <= HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - 3'd1;
          end
        end
        HOLD: begin
          ram_dq_oe <= 1'b0;
          if (owner == OWN_CPU) begin
            cpu_ack <= 1'b1;
          end
`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
          else begin
            vid_valid <= 1'b1;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef KANGAROO_SRAM_VIDEO_PORT_EN
  assign vid_valid = 1'b0;
  assign vid_rdata = '0;
`endif

endmodule

// File: tb/tb_kangaroo_sram_ctrl.sv
// Bench for kangaroo_sram_ctrl: three instances (STROBE_CYCLES 2, 1, 7) each on a 2114 pair model.
// The contention test runs when KANGAROO_SRAM_VIDEO_PORT_EN is defined, the CPU-only test otherwise.
module tb_kangaroo_sram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cpu_req, cpu_we, cpu_ack, cpu_wait, vid_req, vid_valid;
  logic [2:0] ram_cs_n, ram_we_n, ram_dq_oe;
  logic [9:0] cpu_addr [3];
  logic [9:0] vid_addr [3];
  logic [9:0] ram_addr [3];
  logic [7:0] cpu_wdata [3];
  logic [7:0] cpu_rdata [3];
  logic [7:0] vid_rdata [3];
  logic [7:0] ram_dq_out [3];
  logic [7:0] ram_dq_in [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] rd_q [$];
  logic       order_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sc_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 7;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int SC = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [3:0] chip0 [1024];
    logic [3:0] chip1 [1024];

    kangaroo_sram_ctrl #(.STROBE_CYCLES(SC), .ADDR_W(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .cpu_ack    (cpu_ack[g]),
      .cpu_wait   (cpu_wait[g]),
      .vid_req    (vid_req[g]),
      .vid_addr   (vid_addr[g]),
      .vid_rdata  (vid_rdata[g]),
      .vid_valid  (vid_valid[g]),
      .ram_addr   (ram_addr[g]),
      .ram_cs_n   (ram_cs_n[g]),
      .ram_we_n   (ram_we_n[g]),
      .ram_dq_out (ram_dq_out[g]),
      .ram_dq_oe  (ram_dq_oe[g]),
      .ram_dq_in  (ram_dq_in[g])
    );

    // Two 4-bit 2114 chips: low nibble on chip0, high nibble on chip1
    always @(posedge clk) begin
      if (!ram_cs_n[g] && !ram_we_n[g] && ram_dq_oe[g]) begin
        chip0[ram_addr[g]] <= ram_dq_out[g][3:0];
        chip1[ram_addr[g]] <= ram_dq_out[g][7:4];
      end
    end

    assign ram_dq_in[g] = (!ram_cs_n[g] && ram_we_n[g] && !ram_dq_oe[g]) ?
                          {chip1[ram_addr[g]], chip0[ram_addr[g]]} : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access on instance k, started at a negedge with the controller idle
  task automatic applyStimulus(input int k, input logic we, input logic [9:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp_rd);
    int lat, cs_lo, we_lo, oe_hi, we_bad;
    logic done;
    if (!we) rd_q.push_back(exp_rd);
    cpu_req[k] = 1'b1;
    cpu_we[k] = we;
    cpu_addr[k] = addr;
    cpu_wdata[k] = wdata;
    lat = 0; cs_lo = 0; we_lo = 0; oe_hi = 0; we_bad = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!ram_cs_n[k]) cs_lo++;
      if (ram_dq_oe[k]) oe_hi++;
      if (!ram_we_n[k]) begin
        we_lo++;
        if (ram_cs_n[k]) we_bad++;
      end
      if (cpu_ack[k]) done = 1'b1;
    end
    cpu_req[k] = 1'b0;
    checkOutput($sformatf("ack_seen_i%0d", k), done, 1);
    checkOutput($sformatf("latency_i%0d", k), lat - 1, sc_of(k) + 2);
    checkOutput($sformatf("cs_low_i%0d", k), cs_lo, sc_of(k));
    checkOutput($sformatf("we_low_i%0d", k), we_lo, we ? sc_of(k) : 0);
    checkOutput($sformatf("we_outside_cs_i%0d", k), we_bad, 0);
    checkOutput($sformatf("oe_cycles_i%0d", k), oe_hi, we ? sc_of(k) + 2 : 0);
    if (!we) begin
      checkOutput("rd_queue_nonempty", rd_q.size() > 0, 1);
      if (rd_q.size() > 0) checkOutput($sformatf("cpu_rdata_i%0d", k), cpu_rdata[k], rd_q.pop_front());
    end
  endtask

  initial begin
    int found, acks, vids, last_ack, gap_bad, ackc, n;
    logic own;
    reset = 1'b1;
    cpu_req = '0; cpu_we = '0; vid_req = '0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr[i] = '0; vid_addr[i] = '0; cpu_wdata[i] = '0;
    end

    $display("[TB] reset with random requests");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cpu_req = 3'($urandom); cpu_we = 3'($urandom); vid_req = 3'($urandom);
      cpu_addr[0] = 10'($urandom); vid_addr[0] = 10'($urandom); cpu_wdata[0] = 8'($urandom);
      #2;
      checkOutput("rst_cs_n", ram_cs_n, 3'b111);
      checkOutput("rst_we_n", ram_we_n, 3'b111);
      checkOutput("rst_oe", ram_dq_oe, 3'b000);
      checkOutput("rst_ack", {cpu_ack, vid_valid}, 6'b0);
    end
    checkOutput("rst_addr", ram_addr[0], 0);
    checkOutput("rst_dq_out", ram_dq_out[0], 0);
    checkOutput("rst_cpu_rdata", cpu_rdata[0], 0);
    checkOutput("rst_vid_rdata", vid_rdata[0], 0);
    @(negedge clk);
    cpu_req = '0; vid_req = '0;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] cpu write then read");
    applyStimulus(0, 1'b1, 10'h2A5, 8'hDE, 8'h00);
    applyStimulus(0, 1'b0, 10'h2A5, 8'h00, 8'hDE);

    $display("[TB] nibble split and top address");
    applyStimulus(0, 1'b1, 10'h000, 8'h0F, 8'h00);
    applyStimulus(0, 1'b1, 10'h3FF, 8'hF0, 8'h00);
    applyStimulus(0, 1'b0, 10'h000, 8'h00, 8'h0F);
    applyStimulus(0, 1'b0, 10'h3FF, 8'h00, 8'hF0);

    $display("[TB] strobe length 1 and 7");
    for (int k = 1; k < 3; k++) begin
      applyStimulus(k, 1'b1, 10'h155, 8'h3C, 8'h00);
      applyStimulus(k, 1'b0, 10'h155, 8'h00, 8'h3C);
    end

`ifdef KANGAROO_SRAM_VIDEO_PORT_EN
    $display("[TB] cpu and video contention");
    order_q = {1'b1, 1'b0, 1'b1, 1'b0};
    vid_addr[0] = 10'h2A5;
    cpu_addr[0] = 10'h000;
    cpu_we[0] = 1'b0;
    vid_req[0] = 1'b1;
    cpu_req[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (vid_valid[0] || cpu_ack[0]) begin
        own = vid_valid[0];
        n++;
        checkOutput("grant_order_nonempty", order_q.size() > 0, 1);
        if (order_q.size() > 0) checkOutput($sformatf("grant_order_%0d", n), own, order_q.pop_front());
        checkOutput("single_pulse", vid_valid[0] & cpu_ack[0], 0);
        if (own) checkOutput("vid_rdata", vid_rdata[0], 8'hDE);
        else     checkOutput("cpu_rdata_contend", cpu_rdata[0], 8'h0F);
      end else begin
        checkOutput("cpu_wait_held", cpu_wait[0], 1);
      end
    end
    cpu_req[0] = 1'b0;
    vid_req[0] = 1'b0;
    checkOutput("contention_done", n, 4);
    @(negedge clk);
`else
    $display("[TB] video port compiled out, back-to-back cpu reads");
    vid_req[0] = 1'b1;
    vid_addr[0] = 10'h2A5;
    cpu_addr[0] = 10'h3FF;
    cpu_we[0] = 1'b0;
    cpu_req[0] = 1'b1;
    acks = 0; vids = 0; last_ack = 0; gap_bad = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (vid_valid[0]) vids++;
      if (cpu_ack[0]) begin
        if (acks > 0 && (cyc - last_ack) != 5) gap_bad++;
        last_ack = cyc;
        acks++;
        checkOutput("cpu_rdata_b2b", cpu_rdata[0], 8'hF0);
      end
    end
    cpu_req[0] = 1'b0;
    vid_req[0] = 1'b0;
    checkOutput("b2b_acks", acks, 4);
    checkOutput("b2b_spacing_errors", gap_bad, 0);
    checkOutput("vid_valid_pulses", vids, 0);
    checkOutput("vid_rdata_tied", vid_rdata[0], 0);
    @(negedge clk);
`endif

    $display("[TB] reset during strobe");
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 10'h100; cpu_wdata[0] = 8'h55;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (!ram_cs_n[0]) found = 1;
    end
    checkOutput("strobe_reached", found, 1);
    reset = 1'b1;
    #1;
    checkOutput("async_cs_n", ram_cs_n[0], 1);
    checkOutput("async_we_n", ram_we_n[0], 1);
    checkOutput("async_oe", ram_dq_oe[0], 0);
    cpu_req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ackc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_ack[0]) ackc++;
    end
    checkOutput("abandoned_no_ack", ackc, 0);

    applyStimulus(0, 1'b0, 10'h2A5, 8'h00, 8'hDE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
